// File: rtl/mul_uart_sequencer.sv
// mul_uart_sequencer
//   Takes a received UART byte, multiplies it by a constant coefficient on an
//   external multiplier, then sends the 16-bit product back over the UART
//   transmitter high byte first.
//
//   Optional build macro: SEQ_ECHO_EN -- when defined, the operand byte is
//   echoed first, so a response is operand, product[15:8], product[7:0].
//
// Ports
//   clk_fpga     in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   rx_valid     in   one-cycle pulse, byte on rx_data
//   rx_data      in   [7:0] received operand
//   mul_start    out  one-cycle multiplier start pulse
//   mul_a        out  [7:0] latched operand
//   mul_b        out  [7:0] COEFF
//   mul_done     in   multiplier result valid this cycle
//   mul_product  in   [15:0] multiplier result
//   tx_start     out  one-cycle transmit request
//   tx_data      out  [7:0] byte being transmitted
//   tx_active    in   transmitter busy
//   tx_done      in   one-cycle transmit completion
//   busy         out  sequencer not idle
//   overrun      out  sticky: byte received while busy
//   timeout_err  out  sticky: multiplier did not answer in time
module mul_uart_sequencer #(
  parameter logic [7:0] COEFF       = 8'hAA,
  parameter int         MUL_TIMEOUT = 64
) (
  input  logic        clk_fpga,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        mul_start,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic        mul_done,
  input  logic [15:0] mul_product,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_active,
  input  logic        tx_done,
  output logic        busy,
  output logic        overrun,
  output logic        timeout_err
);

  localparam int CW = $clog2(MUL_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE,
    MUL_GO,
    MUL_WAIT,
`ifdef SEQ_ECHO_EN
    ECHO_TX,
    ECHO_WAIT,
`endif
    TX_HI,
    WAIT_HI,
    TX_LO,
    WAIT_LO
  } state_t;

  state_t        r_state, w_next;
  logic [7:0]    r_operand;
  logic [15:0]   r_result;
  logic [CW-1:0] r_cnt;
  logic          r_overrun, r_timeout;
  logic          w_timeout;

  // Next state and decoded outputs. Outputs are decoded from the state so
  // that an asynchronous reset drives them to zero without waiting for a clock.
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    mul_start = 1'b0;
    tx_start  = 1'b0;
    tx_data   = 8'h00;
    case (r_state)
      IDLE: if (rx_valid) w_next = MUL_GO;
      MUL_GO: begin
        mul_start = 1'b1;
        w_next    = MUL_WAIT;
      end
      MUL_WAIT: begin
        if (mul_done) begin
`ifdef SEQ_ECHO_EN
          w_next = ECHO_TX;
`else
          w_next = TX_HI;
`endif
        end else if (r_cnt == CNT_LAST) begin
          // last allowed cycle passed without a result: abandon, no transmit
          w_timeout = 1'b1;
          w_next    = IDLE;
        end
      end
`ifdef SEQ_ECHO_EN
      ECHO_TX: begin
        tx_data = r_operand;
        if (!tx_active) begin
          tx_start = 1'b1;
          w_next   = ECHO_WAIT;
        end
      end
      ECHO_WAIT: begin
        tx_data = r_operand;
        if (tx_done) w_next = TX_HI;
      end
`endif
      TX_HI: begin
        tx_data = r_result[15:8];
        if (!tx_active) begin
          tx_start = 1'b1;
          w_next   = WAIT_HI;
        end
      end
      WAIT_HI: begin
        tx_data = r_result[15:8];
        if (tx_done) w_next = TX_LO;
      end
      TX_LO: begin
        tx_data = r_result[7:0];
        if (!tx_active) begin
          tx_start = 1'b1;
          w_next   = WAIT_LO;
        end
      end
      WAIT_LO: begin
        tx_data = r_result[7:0];
        if (tx_done) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_fpga or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_operand <= 8'h00;
      r_result  <= 16'h0000;
      r_cnt     <= '0;
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && rx_valid) r_operand <= rx_data;
      if (r_state == MUL_WAIT && mul_done) r_result <= mul_product;
      if (r_state == MUL_GO) r_cnt <= '0;
      else if (r_state == MUL_WAIT) r_cnt <= r_cnt + 1'b1;
      // Any byte arriving outside IDLE is dropped, including the cycle that
      // leaves WAIT_LO for IDLE.
      if (rx_valid && r_state != IDLE) r_overrun <= 1'b1;
      if (w_timeout) r_timeout <= 1'b1;
    end
  end

  assign mul_a       = r_operand;
  assign mul_b       = COEFF;
  assign busy        = (r_state != IDLE);
  assign overrun     = r_overrun;
  assign timeout_err = r_timeout;

endmodule

// File: tb/tb_mul_uart_sequencer.sv
module tb_mul_uart_sequencer;

  logic        clk_fpga = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        mul_start;
  logic [7:0]  mul_a, mul_b;
  logic        mul_done;
  logic [15:0] mul_product;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_active, tx_done;
  logic        busy, overrun, timeout_err;

  int checks = 0;
  int errors = 0;
  int tx_count = 0;

  mul_uart_sequencer #(.COEFF(8'hAA), .MUL_TIMEOUT(64)) dut (
    .clk_fpga(clk_fpga), .reset(reset),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_product(mul_product),
    .tx_start(tx_start), .tx_data(tx_data),
    .tx_active(tx_active), .tx_done(tx_done),
    .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk_fpga = ~clk_fpga;

  always @(posedge clk_fpga) if (reset && tx_start) tx_count++;

  typedef struct {
    logic [7:0]  rx;
    int          lat;
    logic [15:0] prod;
    logic [7:0]  exp_hi;
    logic [7:0]  exp_lo;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Serve one transmitted byte. Called and returns on a falling edge.
  task automatic expect_tx(input logic [7:0] exp, input bit inj, input bit rx_at_done,
                           input string nm);
    int n = 0;
    while (!tx_start && n < 200) begin
      @(negedge clk_fpga);
      n++;
    end
    chk({nm, " tx_start seen"}, {31'd0, tx_start}, 32'd1);
    chk({nm, " tx_data"}, {24'd0, tx_data}, {24'd0, exp});
    @(negedge clk_fpga);
    tx_active = 1'b1;
    chk({nm, " tx_start one-shot"}, {31'd0, tx_start}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_fpga);
      chk({nm, " tx_data stable"}, {24'd0, tx_data}, {24'd0, exp});
      rx_valid = (inj && i == 0);
      rx_data  = 8'h05;
    end
    @(negedge clk_fpga);
    rx_valid  = rx_at_done;
    rx_data   = 8'h07;
    tx_done   = 1'b1;
    tx_active = 1'b0;
    @(negedge clk_fpga);
    tx_done  = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic run_txn(input vec_t v, input bit inj, input bit rx_at_done, input string nm);
    rx_valid = 1'b1;
    rx_data  = v.rx;
    @(negedge clk_fpga);
    rx_valid = 1'b0;
    chk({nm, " mul_start"}, {31'd0, mul_start}, 32'd1);
    chk({nm, " mul_a"}, {24'd0, mul_a}, {24'd0, v.rx});
    chk({nm, " mul_b"}, {24'd0, mul_b}, 32'hAA);
    @(negedge clk_fpga);
    chk({nm, " mul_start pulse"}, {31'd0, mul_start}, 32'd0);
    chk({nm, " busy"}, {31'd0, busy}, 32'd1);
    repeat (v.lat) @(negedge clk_fpga);
    mul_done    = 1'b1;
    mul_product = v.prod;
    @(negedge clk_fpga);
    mul_done    = 1'b0;
    mul_product = 16'h0;
    if (v.lat == 0) chk({nm, " min latency"}, {31'd0, tx_start}, 32'd1);
    chk({nm, " mul_a held"}, {24'd0, mul_a}, {24'd0, v.rx});
`ifdef SEQ_ECHO_EN
    expect_tx(v.rx, 1'b0, 1'b0, {nm, " echo"});
`endif
    expect_tx(v.exp_hi, inj, 1'b0, {nm, " hi"});
    expect_tx(v.exp_lo, 1'b0, rx_at_done, {nm, " lo"});
    chk({nm, " idle after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int base;
    vecs[0] = '{8'h03, 8, 16'h01FE, 8'h01, 8'hFE};
    vecs[1] = '{8'hFF, 2, 16'hA956, 8'hA9, 8'h56};
    vecs[2] = '{8'h00, 1, 16'h0000, 8'h00, 8'h00};
    vecs[3] = '{8'h80, 0, 16'h5500, 8'h55, 8'h00};
    vecs[4] = '{8'h01, 5, 16'h00AA, 8'h00, 8'hAA};

    reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h0;
    mul_done = 1'b0; mul_product = 16'h0; tx_active = 1'b0; tx_done = 1'b0;
    #3;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset mul_start", {31'd0, mul_start}, 32'd0);
    chk("reset tx_start", {31'd0, tx_start}, 32'd0);
    chk("reset overrun", {31'd0, overrun}, 32'd0);
    chk("reset timeout", {31'd0, timeout_err}, 32'd0);
    chk("reset mul_a", {24'd0, mul_a}, 32'd0);
    chk("reset tx_data", {24'd0, tx_data}, 32'd0);
    chk("reset mul_b", {24'd0, mul_b}, 32'hAA);
    repeat (2) @(negedge clk_fpga);
    reset = 1'b1;
    @(negedge clk_fpga);

    // Table-driven normal transactions.
    for (int i = 0; i < 5; i++) begin
      base = tx_count;
      run_txn(vecs[i], 1'b0, 1'b0, $sformatf("vec%0d", i));
`ifdef SEQ_ECHO_EN
      chk($sformatf("vec%0d byte count", i), tx_count - base, 3);
`else
      chk($sformatf("vec%0d byte count", i), tx_count - base, 2);
`endif
    end
    chk("no overrun yet", {31'd0, overrun}, 32'd0);
    chk("no timeout yet", {31'd0, timeout_err}, 32'd0);

    // Multiplier timeout: mul_done never comes.
    base = tx_count;
    rx_valid = 1'b1; rx_data = 8'h10;
    @(negedge clk_fpga);
    rx_valid = 1'b0;
    chk("to mul_start", {31'd0, mul_start}, 32'd1);
    repeat (60) @(negedge clk_fpga);
    chk("to still waiting", {31'd0, busy}, 32'd1);
    chk("to not yet flagged", {31'd0, timeout_err}, 32'd0);
    repeat (10) @(negedge clk_fpga);
    chk("to flagged", {31'd0, timeout_err}, 32'd1);
    chk("to idle", {31'd0, busy}, 32'd0);
    chk("to no tx", tx_count - base, 0);
    run_txn(vecs[4], 1'b0, 1'b0, "after timeout");
    chk("timeout sticky", {31'd0, timeout_err}, 32'd1);

    // Overrun: second byte during WAIT_HI is dropped.
    base = tx_count;
    run_txn(vecs[0], 1'b1, 1'b0, "overrun");
    chk("overrun flag", {31'd0, overrun}, 32'd1);
    repeat (5) @(negedge clk_fpga);
`ifdef SEQ_ECHO_EN
    chk("overrun bytes", tx_count - base, 3);
`else
    chk("overrun bytes", tx_count - base, 2);
`endif
    chk("overrun stays idle", {31'd0, busy}, 32'd0);

    // Reset during WAIT_LO aborts the transfer.
    rx_valid = 1'b1; rx_data = 8'h03;
    @(negedge clk_fpga);
    rx_valid = 1'b0;
    @(negedge clk_fpga);
    mul_done = 1'b1; mul_product = 16'h01FE;
    @(negedge clk_fpga);
    mul_done = 1'b0;
`ifdef SEQ_ECHO_EN
    expect_tx(8'h03, 1'b0, 1'b0, "rst echo");
`endif
    expect_tx(8'h01, 1'b0, 1'b0, "rst hi");
    chk("rst lo start", {31'd0, tx_start}, 32'd1);
    @(negedge clk_fpga);
    tx_active = 1'b1;
    chk("rst in WAIT_LO", {24'd0, tx_data}, 32'hFE);
    #2 reset = 1'b0;
    #1;
    chk("mid rst busy", {31'd0, busy}, 32'd0);
    chk("mid rst tx_data", {24'd0, tx_data}, 32'd0);
    chk("mid rst mul_a", {24'd0, mul_a}, 32'd0);
    chk("mid rst overrun", {31'd0, overrun}, 32'd0);
    chk("mid rst timeout", {31'd0, timeout_err}, 32'd0);
    chk("mid rst mul_b", {24'd0, mul_b}, 32'hAA);
    @(negedge clk_fpga);
    tx_active = 1'b0;
    tx_done   = 1'b1;
    @(negedge clk_fpga);
    tx_done = 1'b0;
    reset   = 1'b1;
    base = tx_count;
    repeat (10) @(negedge clk_fpga);
    chk("post rst no tx", tx_count - base, 0);
    chk("post rst idle", {31'd0, busy}, 32'd0);

    // Byte arriving on the WAIT_LO -> IDLE edge is an overrun, not accepted.
    run_txn(vecs[0], 1'b0, 1'b1, "edge rx");
    chk("edge rx overrun", {31'd0, overrun}, 32'd1);
    @(negedge clk_fpga);
    chk("edge rx not accepted", {31'd0, busy}, 32'd0);
    chk("edge rx no mul_start", {31'd0, mul_start}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mul_uart_sequencer.md
MUL_UART_SEQUENCER -- requirements
Module: mul_uart_sequencer

Interface
REQ-001 SHALL have parameter COEFF, default 8'hAA: constant multiplier operand B.
REQ-002 SHALL have parameter MUL_TIMEOUT, default 64: max cycles to wait for mul_done.
REQ-003 clk_fpga  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 rx_valid  input  1  one-cycle pulse: received byte present on rx_data.
REQ-006 rx_data  input  8  received operand byte.
REQ-007 mul_start  output  1  one-cycle pulse starting the multiplier.
REQ-008 mul_a / mul_b  output  8 each  multiplier operands (latched byte / COEFF).
REQ-009 mul_done  input  1  multiplier finished; mul_product valid that cycle.
REQ-010 mul_product  input  16  multiplier result.
REQ-011 tx_start  output  1  one-cycle pulse requesting a UART byte send.
REQ-012 tx_data  output  8  byte to transmit; held stable from tx_start until tx_done.
REQ-013 tx_active / tx_done  input  1 each  transmitter busy / one-cycle completion pulse.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 overrun / timeout_err  output  1 each  sticky error flags.

Function
REQ-016 States SHALL be IDLE, MUL_GO, MUL_WAIT, TX_HI, WAIT_HI, TX_LO, WAIT_LO.
REQ-017 IDLE + rx_valid: latch rx_data into operand register and go to MUL_GO.
REQ-018 MUL_GO: assert mul_start for exactly one cycle, clear timeout counter, go to MUL_WAIT.
REQ-019 mul_a SHALL present the latched operand and mul_b SHALL equal COEFF from MUL_GO until the next IDLE exit.
REQ-020 MUL_WAIT + mul_done: latch mul_product into the result register and go to TX_HI.
REQ-021 MUL_WAIT: count cycles. When the count reaches MUL_TIMEOUT without mul_done, set timeout_err and return to IDLE without transmitting.
REQ-022 TX_HI: tx_data = result[15:8]. Pulse tx_start only when tx_active is low, then go to WAIT_HI. If tx_active is high, stay in TX_HI.
REQ-023 WAIT_HI + tx_done: go to TX_LO.
REQ-024 TX_LO/WAIT_LO: same as TX_HI/WAIT_HI with result[7:0]. On tx_done, go to IDLE.
REQ-025 rx_valid in any state other than IDLE: discard the byte, set overrun, leave FSM state unchanged.
REQ-026 rx_valid in the same cycle as the WAIT_LO→IDLE transition: treat as overrun; the byte is not accepted.
REQ-027 Product width: 16 bits, unsigned. No truncation.
REQ-028 Minimum latency from rx_valid to first tx_start: 3 cycles plus multiplier latency.

Reset
REQ-029 reset low SHALL immediately force IDLE, with all outputs 0 (mul_start, tx_start, busy, overrun, timeout_err, mul_a, tx_data) and all registers 0. mul_b shall equal COEFF.
REQ-030 Reset mid-transfer SHALL abort the transfer. No further tx_start until a new rx_valid follows reset release.
REQ-031 Sticky flags SHALL clear only on reset.

Configuration
REQ-032 Macro SEQ_ECHO_EN: when defined, an ECHO state is inserted before TX_HI (with its TX/WAIT pair) that first transmits the latched operand byte. A response is 3 bytes: operand, product high byte, product low byte.
REQ-033 Without SEQ_ECHO_EN: no ECHO state, and each response is exactly 2 bytes.

Verification
REQ-034 rx_data=8'h03, mul_done after 8 cycles with product 16'h01FE -> tx bytes 8'h01 then 8'hFE; busy low afterwards.
REQ-035 rx_data=8'hFF, product 16'hA956 -> tx 8'hA9, 8'h56; mul_a=8'hFF and mul_b=8'hAA while busy.
REQ-036 mul_done withheld for 64 cycles -> timeout_err=1, no tx_start, back in IDLE; next byte 8'h01 is processed normally.
REQ-037 second rx_valid (8'h05) during WAIT_HI -> overrun=1; only the first byte's product is transmitted.
REQ-038 reset low during WAIT_LO -> outputs 0 immediately; after release, no tx_start until a new rx_valid.
REQ-039 with SEQ_ECHO_EN defined, rx_data=8'h03 -> tx 8'h03, 8'h01, 8'hFE.
